fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of `datapath`: it owns the program counter, reads instruction words from memory over a req/ack handshake, and buffers them in a 2-entry prefetch queue. Its `fetch_data` output drives the datapath's `mem_data` input, and the `control_instruction` strobe of `multi_control` drives `fetch_ready`. A `redirect` input flushes the queue and restarts fetch at a new PC for jumps and branches.

## Interface
- `DATA_BUS_WIDTH`, 36: instruction/memory word width; the datapath uses bits [27:0].
- `ADDR_WIDTH`, 16: PC and memory address width.
- `RESET_PC`, 0: first fetch address after reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `mem_req`  out  1  read request, registered.
- `mem_addr`  out  ADDR_WIDTH  read address, registered; stable while `mem_req`=1.
- `mem_ack`  in  1  memory returns `mem_rdata` this cycle; only meaningful when `mem_req`=1.
- `mem_rdata`  in  DATA_BUS_WIDTH  read data, sampled when `mem_req` && `mem_ack`.
- `fetch_data`  out  DATA_BUS_WIDTH  head-of-queue word, driving datapath `mem_data`.
- `fetch_pc`  out  ADDR_WIDTH  address of `fetch_data`.
- `fetch_valid`  out  1  queue non-empty.
- `fetch_ready`  in  1  consumer accepts the head word this cycle.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address, sampled when `redirect`=1.

## Operation
- **State:**
  - `next_pc` (ADDR_WIDTH).
  - 2-entry FIFO of {data, addr} with `count` 0..2.
  - `mem_req`/`mem_addr` registers.
  - FSM with states RUN and DRAIN.
- **Pop:** occurs when `fetch_valid` && `fetch_ready`. `fetch_data`/`fetch_pc` always show the head entry. With `count`=0, `fetch_data`=0 and `fetch_pc`=0.
- **Push:** occurs when `mem_req` && `mem_ack` in RUN. The pushed entry is {`mem_rdata`, `mem_addr`}.
- **Slot reservation:**
  - An outstanding request reserves one FIFO slot.
  - A new request issues only if `count_next` + (request still outstanding after this edge) < 2.
  - This guarantees an ack never arrives with the FIFO full.
- **Request issue:**
  - On issue, `mem_addr`<=`next_pc`, `mem_req`<=1, `next_pc`<=`next_pc`+1 (mod 2^ADDR_WIDTH; all-ones wraps to 0).
  - After an ack, `mem_req` stays 1 with the incremented address if room remains; otherwise it drops to 0.
- **FSM RUN:** normal fetch.
  - On `redirect`: FIFO cleared (count<=0) and `next_pc`<=`redirect_pc`.
  - If a request is outstanding and not acked this cycle, go to DRAIN.
  - Otherwise `mem_req`<=1, `mem_addr`<=`redirect_pc`, `next_pc`<=`redirect_pc`+1.
- **FSM DRAIN:** hold `mem_req`=1 and `mem_addr` stable until `mem_ack`; the returned data is discarded.
  - On ack, issue `next_pc` in the following cycle and return to RUN.
  - `fetch_valid`=0 throughout DRAIN.
- **Simultaneous events:**
  - `redirect` with a pop: the pop completes, then the flush applies.
  - `redirect` with an ack in RUN: the acked word is discarded.
  - `redirect` in DRAIN: `next_pc` is updated and DRAIN continues.
  - Pop and push in the same cycle: `count` unchanged.
- **Reset (any time, including mid-request):**
  - `mem_req`=0, `mem_addr`=0, `count`=0, `fetch_valid`=0, `fetch_data`=0, `fetch_pc`=0, `next_pc`=`RESET_PC`, state RUN.
  - An outstanding request is abandoned; memory must tolerate a request dropped by reset.

## Timing
- First rising edge after `reset` deasserts: `mem_req`=1, `mem_addr`=`RESET_PC`.
- Ack sampled at edge N: `fetch_valid`=1 with that word from edge N onward, i.e. visible the cycle after the ack cycle.
- Single-cycle memory (ack always 1) with `fetch_ready`=1 sustains one word per cycle.
- Consumer stalled: at most 2 words are buffered, then `mem_req` drops. It re-asserts at the edge that samples a pop.
- Redirect at edge R with no outstanding request: `mem_addr`=`redirect_pc` from R. The first redirected word is valid one cycle after its ack.

## Test plan
- **Reset fetch:** release reset, memory acks every cycle returning data=addr+100, `fetch_ready`=1. Expect `fetch_data` sequence 100, 101, 102… with `fetch_pc` 0, 1, 2… at one per cycle.
- **Backpressure:** `fetch_ready`=0 for 10 cycles. Expect `count`=2, `mem_req`=0, and `fetch_data`=100 held. Release `fetch_ready`: expect 100, 101, 102 in order with no loss or duplicates.
- **Redirect with idle memory:** `redirect`=1, `redirect_pc`=0x40 while 2 words are queued. Next cycle expect `fetch_valid`=0 and `mem_addr`=0x40. Then expect data from 0x40, 0x41.
- **Redirect mid-request:** memory with ack latency 3 gets `redirect` to 0x80 one cycle after a request to 0x05. Expect `mem_addr` 0x05 held until ack and the word discarded. Then expect a request to 0x80, with the first `fetch_pc`=0x80.
- **Wrap:** redirect to 0xFFFF. Expect `fetch_pc` 0xFFFF then 0x0000.
- **Async reset mid-operation:** assert `reset` between edges with `mem_req`=1 and 2 words queued. Expect immediate `mem_req`=0, `fetch_valid`=0, `fetch_data`=0. After release, expect the first fetch at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack memory reads and holds
// fetched words in a 2-entry prefetch queue. A redirect flushes and restarts fetch.
//   state    | meaning
//   ST_RUN   | normal fetch, queue filled on ack
//   ST_DRAIN | waiting out a request made stale by a redirect, data discarded
`timescale 1ns/1ps
module fetch_unit #(
    parameter int unsigned           DATA_BUS_WIDTH = 36,
    parameter int unsigned           ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      mem_req_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    input  logic                      mem_ack_i,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_BUS_WIDTH-1:0] fetch_data_o,
    output logic [ADDR_WIDTH-1:0]     fetch_pc_o,
    output logic                      fetch_valid_o,
    input  logic                      fetch_ready_i,
    input  logic                      redirect_i,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc_i
);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     next_pc_q, next_pc_d;
    logic                      req_q, req_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [1:0]                count_q, count_d;
    logic [DATA_BUS_WIDTH-1:0] data_q [2];
    logic [DATA_BUS_WIDTH-1:0] data_d [2];
    logic [ADDR_WIDTH-1:0]     pc_q [2];
    logic [ADDR_WIDTH-1:0]     pc_d [2];

    logic                      pop;
    logic                      ack;
    logic                      outstanding;
    logic [1:0]                count_after_pop;
    logic [ADDR_WIDTH-1:0]     drain_target;

    assign fetch_valid_o = (count_q != 2'd0) && (state_q == ST_RUN);
    assign fetch_data_o  = fetch_valid_o ? data_q[0] : '0;
    assign fetch_pc_o    = fetch_valid_o ? pc_q[0] : '0;
    assign mem_req_o     = req_q;
    assign mem_addr_o    = addr_q;

    assign pop             = fetch_valid_o && fetch_ready_i;
    assign ack             = req_q && mem_ack_i;
    assign outstanding     = req_q && !mem_ack_i;
    assign count_after_pop = count_q - {1'b0, pop};
    assign drain_target    = redirect_i ? redirect_pc_i : next_pc_q;

    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        count_d   = count_q;
        data_d    = data_q;
        pc_d      = pc_q;

        case (state_q)
            ST_RUN: begin
                if (pop) begin
                    data_d[0] = data_q[1];
                    pc_d[0]   = pc_q[1];
                end
                if (redirect_i) begin
                    count_d = 2'd0;
                    if (outstanding) begin
                        state_d   = ST_DRAIN;
                        next_pc_d = redirect_pc_i;
                    end else begin
                        req_d     = 1'b1;
                        addr_d    = redirect_pc_i;
                        next_pc_d = redirect_pc_i + ADDR_WIDTH'(1);
                    end
                end else begin
                    count_d = count_after_pop;
                    if (ack) begin
                        // slot reservation guarantees count_after_pop <= 1 here
                        if (count_after_pop == 2'd0) begin
                            data_d[0] = mem_rdata_i;
                            pc_d[0]   = addr_q;
                        end else begin
                            data_d[1] = mem_rdata_i;
                            pc_d[1]   = addr_q;
                        end
                        count_d = count_after_pop + 2'd1;
                    end
                    if (!outstanding) begin
                        if (count_d < 2'd2) begin
                            req_d     = 1'b1;
                            addr_d    = next_pc_q;
                            next_pc_d = next_pc_q + ADDR_WIDTH'(1);
                        end else begin
                            req_d = 1'b0;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                next_pc_d = drain_target;
                if (ack) begin
                    state_d   = ST_RUN;
                    req_d     = 1'b1;
                    addr_d    = drain_target;
                    next_pc_d = drain_target + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            next_pc_q <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= '0;
            count_q   <= 2'd0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
            pc_q[0]   <= pc_d[0];
            pc_q[1]   <= pc_d[1];
        end
    end

endmodule
